// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down counter command-side driver.
package counter_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        STEP = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } drv_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_driver_pacer.sv
// Step-pacing down-counter: reloaded on every step pulse, counts idle cycles in WAIT.
module counter_driver_pacer #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_tick,
    output logic             o_expired
);

    logic [DIV_W-1:0] cnt_q;

    // Loaded with div-1 so that the last idle cycle is the one where the count reads zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_div - {{(DIV_W-1){1'b0}}, 1'b1};
        end else if (i_tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/counter_driver.sv
// Command-side master for an up/down counter: reaches a target by load or by paced shortest-path steps.
module counter_driver
    import counter_pkg::*;
#(
    parameter int N     = 8,
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [N-1:0]     i_cmd_target,
    input  logic             i_cmd_load,
    input  logic [DIV_W-1:0] i_step_div,
    input  logic             i_abort,
    output logic             o_en,
    output logic             o_load,
    output logic             o_dir,
    output logic [N-1:0]     o_data,
    output logic [N-1:0]     o_pos,
    output logic             o_busy,
    output logic             o_done
);

    drv_state_t       state_q;
    logic [DIV_W-1:0] div_q;
    logic [N:0]       rem_q;
    logic [N-1:0]     pos_q;
    logic [N-1:0]     data_q;
    logic             en_q;
    logic             load_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;

    logic [N-1:0]     d_up;
    logic [N:0]       d_up_x;
    logic [N:0]       d_dn_x;
    logic             step_dir;
    logic [N:0]       step_rem;
    logic             pace_expired;

    // Distances carried in N+1 bits so the half-way tie and 2^N - d_up are exact.
    assign d_up     = i_cmd_target - pos_q;
    assign d_up_x   = {1'b0, d_up};
    assign d_dn_x   = {1'b1, {N{1'b0}}} - d_up_x;
    assign step_dir = (d_up_x <= {2'b01, {(N-1){1'b0}}});
    assign step_rem = step_dir ? d_up_x : d_dn_x;

    counter_driver_pacer #(
        .DIV_W (DIV_W)
    ) u_pacer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (state_q == STEP),
        .i_div     (div_q),
        .i_tick    (state_q == WAIT),
        .o_expired (pace_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            rem_q   <= '0;
            pos_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            load_q  <= 1'b0;
            dir_q   <= DIR_DOWN;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_cmd_valid) begin
                        div_q  <= i_step_div;
                        busy_q <= 1'b1;
                        if (i_cmd_load) begin
                            state_q <= LOAD;
                            en_q    <= 1'b1;
                            load_q  <= 1'b1;
                            dir_q   <= DIR_DOWN;
                            data_q  <= i_cmd_target;
                        end else if (d_up == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= STEP;
                            en_q    <= 1'b1;
                            load_q  <= 1'b0;
                            dir_q   <= step_dir;
                            rem_q   <= step_rem;
                        end
                    end
                end
                LOAD: begin
                    pos_q   <= data_q;
                    en_q    <= 1'b0;
                    load_q  <= 1'b0;
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                STEP: begin
                    // The pulse on o_en this cycle always lands, so the shadow follows it even on abort.
                    pos_q <= (dir_q == DIR_UP) ? pos_q + N'(1) : pos_q - N'(1);
                    rem_q <= rem_q - (N+1)'(1);
                    if (i_abort) begin
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (rem_q == (N+1)'(1)) begin
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (div_q != '0) begin
                        en_q    <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (pace_expired) begin
                        en_q    <= 1'b1;
                        state_q <= STEP;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    en_q    <= 1'b0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = (state_q == IDLE) && !i_rst;
    assign o_en        = en_q;
    assign o_load      = load_q;
    assign o_dir       = dir_q;
    assign o_data      = data_q;
    assign o_pos       = pos_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_counter_driver.sv
// Drives counter_driver against a behavioural counter and a shortest-path reference model.
module tb_counter_driver;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic       cmd_load;
    logic [7:0] step_div;
    logic       abort;
    logic       en;
    logic       ld;
    logic       dir;
    logic [7:0] data;
    logic [7:0] pos;
    logic       busy;
    logic       done;

    logic [7:0] ctr_val;
    logic       ctr_rst_n;

    int n_chk;
    int n_fail;
    int exp_pos;

    counter_driver #(
        .N     (8),
        .DIV_W (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_target (cmd_target),
        .i_cmd_load   (cmd_load),
        .i_step_div   (step_div),
        .i_abort      (abort),
        .o_en         (en),
        .o_load       (ld),
        .o_dir        (dir),
        .o_data       (data),
        .o_pos        (pos),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached counter: active-low reset fed from the inverted driver reset.
    assign ctr_rst_n = ~rst;
    always @(posedge clk) begin
        if (!ctr_rst_n)
            ctr_val <= 8'h00;
        else if (en)
            ctr_val <= ld ? data : (dir ? ctr_val + 8'h01 : ctr_val - 8'h01);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) break;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic run_cmd(input logic [7:0] tgt, input logic ldf, input logic [7:0] dv);
        int  d, n, exp_done, final_pos, pulses, done_off;
        bit  up, seen;
        wait_ready();
        d = (int'(tgt) - exp_pos + 256) % 256;
        up = 1'b0;
        if (ldf) begin
            n = 1; exp_done = 2; final_pos = int'(tgt);
        end else if (d == 0) begin
            n = 0; exp_done = 1; final_pos = exp_pos;
        end else begin
            up        = (d <= 128);
            n         = up ? d : 256 - d;
            exp_done  = 1 + (n - 1) * (int'(dv) + 1) + 1;
            final_pos = up ? (exp_pos + n) % 256 : (exp_pos - n + 256) % 256;
        end
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_load   = ldf;
        step_div   = dv;
        pulses = 0; seen = 1'b0; done_off = -1;
        for (int t = 1; t <= exp_done + 8 && !seen; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("pos_vs_counter", {24'd0, pos}, {24'd0, ctr_val});
            chk("busy_during", {31'd0, busy}, 32'd1);
            if (en === 1'b1) begin
                chk("pulse_time", t, ldf ? 1 : 1 + pulses * (int'(dv) + 1));
                chk("pulse_load", {31'd0, ld}, {31'd0, ldf});
                if (ldf) chk("load_data", {24'd0, data}, {24'd0, tgt});
                else     chk("pulse_dir", {31'd0, dir}, {31'd0, up});
                pulses++;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                done_off = t;
                chk("ready_in_done", {31'd0, cmd_ready}, 32'd0);
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("done_time", done_off, exp_done);
        chk("pulse_count", pulses, n);
        chk("final_pos", {24'd0, pos}, final_pos);
        $display("cmd tgt=%02h load=%0d div=%0d pulses=%0d done@%0d pos=%02h", tgt, ldf, dv, pulses, done_off, pos);
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("done_once", {31'd0, done}, 32'd0);
        exp_pos = final_pos;
    endtask

    initial begin
        int  pulses;
        bit  aborted, seen;
        n_chk = 0; n_fail = 0; exp_pos = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_target = 8'h00; cmd_load = 1'b0;
        step_div = 8'h00; abort = 1'b0;

        // Reset held three cycles.
        repeat (3) @(negedge clk);
        chk("rst_en",    {31'd0, en},        32'd0);
        chk("rst_load",  {31'd0, ld},        32'd0);
        chk("rst_dir",   {31'd0, dir},       32'd0);
        chk("rst_data",  {24'd0, data},      32'd0);
        chk("rst_pos",   {24'd0, pos},       32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_done",  {31'd0, done},      32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        $display("reset released ready=%0d", cmd_ready);

        // Directed moves.
        run_cmd(8'h03, 1'b0, 8'd0);
        run_cmd(8'h02, 1'b1, 8'd0);
        run_cmd(8'hFE, 1'b0, 8'd1);
        run_cmd(8'h00, 1'b1, 8'd0);
        run_cmd(8'h80, 1'b0, 8'd0);
        run_cmd(8'h10, 1'b1, 8'd0);
        run_cmd(8'h10, 1'b0, 8'd0);
        run_cmd(8'h5A, 1'b1, 8'd0);
        run_cmd(8'h00, 1'b1, 8'd0);

        // Abort while the 5th pulse is on o_en.
        wait_ready();
        cmd_valid = 1'b1; cmd_target = 8'h40; cmd_load = 1'b0; step_div = 8'd2;
        pulses = 0; aborted = 1'b0; seen = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            abort = 1'b0;
            chk("abort_pos_vs_counter", {24'd0, pos}, {24'd0, ctr_val});
            if (en === 1'b1) pulses++;
            if (done === 1'b1) seen = 1'b1;
            if (pulses == 5 && !aborted) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
        end
        chk("abort_pulses", pulses, 5);
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        chk("abort_pos", {24'd0, pos}, 32'h05);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        $display("abort tgt=40 div=2 pulses=%0d pos=%02h", pulses, pos);
        exp_pos = 5;

        // Reset in the middle of a move.
        wait_ready();
        cmd_valid = 1'b1; cmd_target = 8'h40; cmd_load = 1'b0; step_div = 8'd0;
        pulses = 0;
        for (int t = 1; t <= 10 && pulses < 3; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (en === 1'b1) pulses++;
        end
        chk("rstmid_pulses", pulses, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_en",    {31'd0, en},        32'd0);
        chk("rstmid_pos",   {24'd0, pos},       32'd0);
        chk("rstmid_ctr",   {24'd0, ctr_val},   32'd0);
        chk("rstmid_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rstmid_busy",  {31'd0, busy},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("rstmid_en_after",    {31'd0, en},        32'd0);
        $display("reset mid-move pos=%02h counter=%02h", pos, ctr_val);
        exp_pos = 0;

        // Random commands.
        for (int i = 0; i < 16; i++) begin
            run_cmd(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                    8'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
